// File: rtl/dfi_phy_responder.sv
// DFI PHY-side responder: decodes DFI commands, tracks open banks, stores write data
// and returns read data after a fixed PHY read latency, flagging protocol errors.
module dfi_phy_responder #(
  parameter int BANK_W      = 3,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 64,
  parameter int ROW_BITS    = 2,
  parameter int COL_BITS    = 4,
  parameter int TPHY_WRLAT  = 2,
  parameter int TPHY_RDLAT  = 4,
  parameter int INIT_CYCLES = 16
) (
  input  logic                  core_clk,
  input  logic                  core_reset,
  input  logic                  dfi_cs_n,
  input  logic                  dfi_ras_n,
  input  logic                  dfi_cas_n,
  input  logic                  dfi_we_n,
  input  logic [BANK_W-1:0]     dfi_bank,
  input  logic [ADDR_W-1:0]     dfi_address,
  input  logic                  dfi_wrdata_en,
  input  logic [DATA_W-1:0]     dfi_wrdata,
  input  logic [DATA_W/8-1:0]   dfi_wrdata_mask,
  input  logic                  dfi_rddata_en,
  output logic [DATA_W-1:0]     dfi_rddata,
  output logic                  dfi_rddata_valid,
  input  logic                  dfi_init_start,
  output logic                  dfi_init_complete,
  output logic [5:0]            err
);

  localparam int IDX_W  = BANK_W + ROW_BITS + COL_BITS;
  localparam int NBANK  = 1 << BANK_W;
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(INIT_CYCLES + 1);

  if (TPHY_WRLAT < 1 || TPHY_WRLAT > 7 || TPHY_RDLAT < 1 || TPHY_RDLAT > 7) begin : g_bad_latency
    $error("dfi_phy_responder: TPHY_WRLAT and TPHY_RDLAT must be in 1..7");
  end

  typedef enum logic [1:0] {S_RESET, S_WAIT_START, S_COUNT, S_READY} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NBANK-1:0]   r_open;
  logic [ADDR_W-1:0]  r_row [NBANK];
  logic [DATA_W-1:0]  r_mem [2**IDX_W];

  logic [IDX_W-1:0]   r_wr_fifo [4];
  logic [1:0]         r_wr_wptr, r_wr_rptr;
  logic [2:0]         r_wr_cnt;
  logic [IDX_W-1:0]   r_rd_fifo [4];
  logic [1:0]         r_rd_wptr, r_rd_rptr;
  logic [2:0]         r_rd_cnt;

  logic [TPHY_RDLAT-1:0] r_pipe_v;
  logic [DATA_W-1:0]     r_pipe_d [TPHY_RDLAT];

  logic               w_sel, w_act, w_rd, w_wr, w_pre, w_ref, w_any, w_ready;
  logic [2:0]         w_cmd;
  logic               w_bank_open;
  logic [ADDR_W-1:0]  w_row;
  logic [IDX_W-1:0]   w_idx, w_wr_head, w_rd_head;
  logic               w_wr_full, w_wr_empty, w_rd_full, w_rd_empty;
  logic               w_wr_push, w_wr_pop, w_rd_push, w_rd_pop;
  logic [5:0]         w_err_set;
  logic               w_unused_row;

  assign w_sel   = ~dfi_cs_n;
  assign w_cmd   = {dfi_ras_n, dfi_cas_n, dfi_we_n};
  assign w_act   = w_sel && (w_cmd == 3'b011);
  assign w_rd    = w_sel && (w_cmd == 3'b101);
  assign w_wr    = w_sel && (w_cmd == 3'b100);
  assign w_pre   = w_sel && (w_cmd == 3'b010);
  assign w_ref   = w_sel && (w_cmd == 3'b001);
  assign w_any   = w_act || w_rd || w_wr || w_pre || w_ref;
  assign w_ready = (r_state == S_READY);

  assign w_bank_open  = r_open[dfi_bank];
  assign w_row        = r_row[dfi_bank];
  assign w_idx        = {dfi_bank, w_row[ROW_BITS-1:0], dfi_address[COL_BITS-1:0]};
  // Only the low row bits select storage; the rest of the open row is tracked but not needed here.
  assign w_unused_row = ^w_row[ADDR_W-1:ROW_BITS];

  assign w_wr_full  = (r_wr_cnt == 3'd4);
  assign w_wr_empty = (r_wr_cnt == 3'd0);
  assign w_rd_full  = (r_rd_cnt == 3'd4);
  assign w_rd_empty = (r_rd_cnt == 3'd0);
  assign w_wr_head  = r_wr_fifo[r_wr_rptr];
  assign w_rd_head  = r_rd_fifo[r_rd_rptr];

  // Push legality uses the pre-pop occupancy and pop legality the pre-push one.
  assign w_wr_push = w_ready && w_wr && w_bank_open && !w_wr_full;
  assign w_rd_push = w_ready && w_rd && w_bank_open && !w_rd_full;
  assign w_wr_pop  = dfi_wrdata_en && !w_wr_empty;
  assign w_rd_pop  = dfi_rddata_en && !w_rd_empty;

  assign w_err_set[0] = w_any && !w_ready;
  assign w_err_set[1] = w_ready && w_act && w_bank_open;
  assign w_err_set[2] = w_ready && (w_rd || w_wr) && !w_bank_open;
  assign w_err_set[3] = w_ready && w_ref && (|r_open);
  assign w_err_set[4] = (dfi_wrdata_en && w_wr_empty) || (w_ready && w_wr && w_wr_full);
  assign w_err_set[5] = (dfi_rddata_en && w_rd_empty) || (w_ready && w_rd && w_rd_full);

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      r_state           <= S_RESET;
      r_cnt             <= '0;
      dfi_init_complete <= 1'b0;
    end else begin
      case (r_state)
        S_RESET:      r_state <= S_WAIT_START;
        S_WAIT_START: begin
          if (dfi_init_start) begin
            r_state <= S_COUNT;
            r_cnt   <= '0;
          end
        end
        S_COUNT: begin
          if (r_cnt == CNT_W'(INIT_CYCLES - 1)) begin
            r_state           <= S_READY;
            dfi_init_complete <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READY:      r_state <= S_READY;
        default:      r_state <= S_RESET;
      endcase
    end
  end

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      r_open <= '0;
      err    <= '0;
      for (int i = 0; i < NBANK; i++) r_row[i] <= '0;
    end else begin
      err <= err | w_err_set;
      if (w_ready && w_act && !w_bank_open) begin
        r_open[dfi_bank] <= 1'b1;
        r_row[dfi_bank]  <= dfi_address;
      end
      if (w_ready && w_pre) begin
        if (dfi_address[10]) r_open <= '0;
        else                 r_open[dfi_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      r_wr_wptr <= '0;
      r_wr_rptr <= '0;
      r_wr_cnt  <= '0;
      for (int i = 0; i < 4; i++) r_wr_fifo[i] <= '0;
    end else begin
      if (w_wr_push) begin
        r_wr_fifo[r_wr_wptr] <= w_idx;
        r_wr_wptr            <= r_wr_wptr + 1'b1;
      end
      if (w_wr_pop) r_wr_rptr <= r_wr_rptr + 1'b1;
      r_wr_cnt <= r_wr_cnt + {2'b00, w_wr_push} - {2'b00, w_wr_pop};
    end
  end

  // Storage deliberately has no reset so written data survives a controller reset.
  always_ff @(posedge core_clk) begin
    if (w_wr_pop) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!dfi_wrdata_mask[b]) r_mem[w_wr_head][b*8 +: 8] <= dfi_wrdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      r_rd_wptr <= '0;
      r_rd_rptr <= '0;
      r_rd_cnt  <= '0;
      r_pipe_v  <= '0;
      for (int i = 0; i < 4; i++) r_rd_fifo[i] <= '0;
      for (int i = 0; i < TPHY_RDLAT; i++) r_pipe_d[i] <= '0;
    end else begin
      if (w_rd_push) begin
        r_rd_fifo[r_rd_wptr] <= w_idx;
        r_rd_wptr            <= r_rd_wptr + 1'b1;
      end
      if (w_rd_pop) r_rd_rptr <= r_rd_rptr + 1'b1;
      r_rd_cnt <= r_rd_cnt + {2'b00, w_rd_push} - {2'b00, w_rd_pop};
      // Each stage only takes new data alongside a valid, so the last stage holds its value.
      for (int i = TPHY_RDLAT - 1; i > 0; i--) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        if (r_pipe_v[i-1]) r_pipe_d[i] <= r_pipe_d[i-1];
      end
      r_pipe_v[0] <= w_rd_pop;
      if (w_rd_pop) r_pipe_d[0] <= r_mem[w_rd_head];
    end
  end

  assign dfi_rddata       = r_pipe_d[TPHY_RDLAT-1];
  assign dfi_rddata_valid = r_pipe_v[TPHY_RDLAT-1];

endmodule

// File: tb/tb_dfi_phy_responder.sv
// Randomised, self-checking bench for dfi_phy_responder against a queue-based
// behavioural model of the DFI responder rules.
module tb_dfi_phy_responder;

  localparam int BANK_W      = 3;
  localparam int ADDR_W      = 14;
  localparam int DATA_W      = 64;
  localparam int ROW_BITS    = 2;
  localparam int COL_BITS    = 4;
  localparam int TPHY_RDLAT  = 4;
  localparam int INIT_CYCLES = 16;
  localparam int NWORDS      = 1 << (BANK_W + ROW_BITS + COL_BITS);

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [63:0] WORD_A = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] WORD_B = 64'hFFFFFFFF_CAFEF00D;

  logic                 core_clk;
  logic                 core_reset;
  logic                 dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [BANK_W-1:0]    dfi_bank;
  logic [ADDR_W-1:0]    dfi_address;
  logic                 dfi_wrdata_en;
  logic [DATA_W-1:0]    dfi_wrdata;
  logic [DATA_W/8-1:0]  dfi_wrdata_mask;
  logic                 dfi_rddata_en;
  logic [DATA_W-1:0]    dfi_rddata;
  logic                 dfi_rddata_valid;
  logic                 dfi_init_start;
  logic                 dfi_init_complete;
  logic [5:0]           err;

  int checks = 0;
  int passes = 0;

  dfi_phy_responder #(
    .BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_BITS(ROW_BITS),
    .COL_BITS(COL_BITS), .TPHY_WRLAT(2), .TPHY_RDLAT(TPHY_RDLAT), .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .core_clk(core_clk), .core_reset(core_reset),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_bank(dfi_bank), .dfi_address(dfi_address),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata), .dfi_wrdata_mask(dfi_wrdata_mask),
    .dfi_rddata_en(dfi_rddata_en), .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid),
    .dfi_init_start(dfi_init_start), .dfi_init_complete(dfi_init_complete), .err(err)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // Behavioural model state
  typedef struct {
    int          due;
    logic [63:0] data;
    bit          known;
  } pipe_t;

  bit          mOpen [8];
  logic [13:0] mRow [8];
  logic [63:0] mMem [NWORDS];
  bit   [7:0]  mKnown [NWORDS];
  int          mWrQ [$];
  int          mRdQ [$];
  pipe_t       mPipe [$];
  logic [5:0]  mErr;
  logic        mExpValid;
  logic [63:0] mExpData;
  bit          mExpKnown;
  logic        mExpInit;
  int          mEdge;
  int          mStartEdge;

  function automatic int wordIndex(input int bank, input int row, input int col);
    return bank * (1 << (ROW_BITS + COL_BITS)) + (row % (1 << ROW_BITS)) * (1 << COL_BITS)
           + (col % (1 << COL_BITS));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      mOpen[i] = 0;
      mRow[i]  = '0;
    end
    mWrQ.delete();
    mRdQ.delete();
    mPipe.delete();
    mErr       = '0;
    mExpValid  = 1'b0;
    mExpData   = '0;
    mExpKnown  = 1;
    mExpInit   = 1'b0;
    mEdge      = 0;
    mStartEdge = -1;
  endtask

  // Applies the responder rules to the inputs sampled at one rising edge.
  task automatic modelEdge();
    int wqn, rqn, idx, bank;
    bit ready, anyOpen;
    logic [2:0] cmd;
    pipe_t e;
    if (core_reset) begin
      modelReset();
      return;
    end
    mEdge++;
    ready = (mStartEdge >= 0) && (mEdge - 1 >= mStartEdge + INIT_CYCLES);
    if (mStartEdge < 0 && mEdge >= 2 && dfi_init_start) mStartEdge = mEdge;
    wqn = mWrQ.size();
    rqn = mRdQ.size();
    bank = int'(dfi_bank);
    if (dfi_rddata_en) begin
      if (rqn == 0) mErr[5] = 1'b1;
      else begin
        idx     = mRdQ.pop_front();
        e.due   = mEdge + TPHY_RDLAT - 1;
        e.data  = mMem[idx];
        e.known = (mKnown[idx] == 8'hFF);
        mPipe.push_back(e);
      end
    end
    if (dfi_wrdata_en) begin
      if (wqn == 0) mErr[4] = 1'b1;
      else begin
        idx = mWrQ.pop_front();
        for (int b = 0; b < 8; b++) begin
          if (!dfi_wrdata_mask[b]) begin
            mMem[idx][8*b +: 8] = dfi_wrdata[8*b +: 8];
            mKnown[idx][b] = 1'b1;
          end
        end
      end
    end
    cmd = {dfi_ras_n, dfi_cas_n, dfi_we_n};
    anyOpen = 0;
    for (int i = 0; i < 8; i++) if (mOpen[i]) anyOpen = 1;
    if (!dfi_cs_n && (cmd inside {C_ACT, C_RD, C_WR, C_PRE, C_REF})) begin
      if (!ready) mErr[0] = 1'b1;
      else begin
        case (cmd)
          C_ACT: begin
            if (mOpen[bank]) mErr[1] = 1'b1;
            else begin
              mOpen[bank] = 1;
              mRow[bank]  = dfi_address;
            end
          end
          C_RD: begin
            if (!mOpen[bank]) mErr[2] = 1'b1;
            if (rqn == 4) mErr[5] = 1'b1;
            if (mOpen[bank] && rqn < 4) mRdQ.push_back(wordIndex(bank, int'(mRow[bank]), int'(dfi_address)));
          end
          C_WR: begin
            if (!mOpen[bank]) mErr[2] = 1'b1;
            if (wqn == 4) mErr[4] = 1'b1;
            if (mOpen[bank] && wqn < 4) mWrQ.push_back(wordIndex(bank, int'(mRow[bank]), int'(dfi_address)));
          end
          C_PRE: begin
            if (dfi_address[10]) for (int i = 0; i < 8; i++) mOpen[i] = 0;
            else mOpen[bank] = 0;
          end
          default: if (anyOpen) mErr[3] = 1'b1;
        endcase
      end
    end
    if (mPipe.size() > 0 && mPipe[0].due == mEdge) begin
      e = mPipe.pop_front();
      mExpValid = 1'b1;
      mExpData  = e.data;
      mExpKnown = e.known;
    end else begin
      mExpValid = 1'b0;
    end
    mExpInit = (mStartEdge >= 0) && (mEdge >= mStartEdge + INIT_CYCLES);
  endtask

  task automatic idleInputs();
    dfi_cs_n = 1'b1; dfi_ras_n = 1'b1; dfi_cas_n = 1'b1; dfi_we_n = 1'b1;
    dfi_bank = '0; dfi_address = '0;
    dfi_wrdata_en = 1'b0; dfi_wrdata = '0; dfi_wrdata_mask = '0;
    dfi_rddata_en = 1'b0; dfi_init_start = 1'b0;
  endtask

  task automatic setCmd(input logic [2:0] cmd, input int bank, input int addr);
    dfi_cs_n = 1'b0;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = cmd;
    dfi_bank = BANK_W'(bank);
    dfi_address = ADDR_W'(addr);
  endtask

  // One clock: DUT and model see the same inputs; returns at the falling edge.
  task automatic tick();
    @(posedge core_clk);
    modelEdge();
    @(negedge core_clk);
    idleInputs();
  endtask

  task automatic test_reset();
    core_reset = 1'b1;
    idleInputs();
    modelReset();
    tick();
    tick();
    checks++; if (dfi_rddata !== 64'd0) $display("FAIL reset_rddata: got %h want 0", dfi_rddata); else passes++;
    checks++; if (dfi_rddata_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dfi_rddata_valid); else passes++;
    checks++; if (dfi_init_complete !== 1'b0) $display("FAIL reset_init: got %b want 0", dfi_init_complete); else passes++;
    checks++; if (err !== 6'd0) $display("FAIL reset_err: got %b want 0", err); else passes++;
  endtask

  task automatic test_init();
    int riseCycle = -1;
    core_reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) dfi_init_start = 1'b1;
      if (c == 10) setCmd(C_ACT, 1, 5);
      tick();
      if (dfi_init_complete === 1'b1 && riseCycle < 0) riseCycle = c + 1;
      checks++; if (dfi_init_complete !== mExpInit) $display("FAIL init_complete c%0d: got %b want %b", c, dfi_init_complete, mExpInit); else passes++;
      checks++; if (err !== mErr) $display("FAIL init_err c%0d: got %b want %b", c, err, mErr); else passes++;
    end
    checks++; if (riseCycle != 5 + INIT_CYCLES + 1) $display("FAIL init_rise_cycle: got %0d want %0d", riseCycle, 5 + INIT_CYCLES + 1); else passes++;
    checks++; if (err[0] !== 1'b1) $display("FAIL init_early_act_err0: got %b want 1", err[0]); else passes++;
  endtask

  task automatic test_write_read();
    setCmd(C_ACT, 2, 1); tick();
    setCmd(C_WR, 2, 3);  tick();
    tick();
    dfi_wrdata_en = 1'b1; dfi_wrdata = WORD_A; dfi_wrdata_mask = 8'h00; tick();
    setCmd(C_RD, 2, 3); tick();
    dfi_rddata_en = 1'b1; tick();
    for (int d = 1; d <= 6; d++) begin
      checks++; if (dfi_rddata_valid !== (d == TPHY_RDLAT)) $display("FAIL wr_rd_valid d%0d: got %b want %b", d, dfi_rddata_valid, d == TPHY_RDLAT); else passes++;
      if (d == TPHY_RDLAT) begin
        checks++; if (dfi_rddata !== WORD_A) $display("FAIL wr_rd_data: got %h want %h", dfi_rddata, WORD_A); else passes++;
      end
      tick();
    end
    checks++; if (err !== mErr) $display("FAIL wr_rd_err: got %b want %b", err, mErr); else passes++;
  endtask

  task automatic test_byte_mask();
    setCmd(C_WR, 2, 3); tick();
    dfi_wrdata_en = 1'b1; dfi_wrdata = '1; dfi_wrdata_mask = 8'h0F; tick();
    setCmd(C_RD, 2, 3); tick();
    dfi_rddata_en = 1'b1; tick();
    for (int d = 1; d <= 6; d++) begin
      checks++; if (dfi_rddata_valid !== mExpValid) $display("FAIL mask_valid d%0d: got %b want %b", d, dfi_rddata_valid, mExpValid); else passes++;
      if (d == TPHY_RDLAT) begin
        checks++; if (dfi_rddata !== WORD_B) $display("FAIL mask_data: got %h want %h", dfi_rddata, WORD_B); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_bank_errors();
    setCmd(C_RD, 0, 0); tick();
    checks++; if (err[2] !== 1'b1) $display("FAIL bank_rd_closed_err2: got %b want 1", err[2]); else passes++;
    setCmd(C_ACT, 2, 7); tick();
    checks++; if (err[1] !== 1'b1) $display("FAIL bank_act_open_err1: got %b want 1", err[1]); else passes++;
    setCmd(C_REF, 0, 0); tick();
    checks++; if (err[3] !== 1'b1) $display("FAIL bank_ref_open_err3: got %b want 1", err[3]); else passes++;
    checks++; if (err !== mErr) $display("FAIL bank_err_word: got %b want %b", err, mErr); else passes++;
    // Row must still be 1 and the rejected RD must not have queued anything.
    setCmd(C_RD, 2, 3); tick();
    dfi_rddata_en = 1'b1; tick();
    for (int d = 1; d <= 6; d++) begin
      checks++; if (dfi_rddata_valid !== (d == TPHY_RDLAT)) $display("FAIL bank_keep_valid d%0d: got %b want %b", d, dfi_rddata_valid, d == TPHY_RDLAT); else passes++;
      if (d == TPHY_RDLAT) begin
        checks++; if (dfi_rddata !== WORD_B) $display("FAIL bank_keep_data: got %h want %h", dfi_rddata, WORD_B); else passes++;
      end
      tick();
    end
    checks++; if (err[5] !== 1'b0) $display("FAIL bank_no_rd_err5: got %b want 0", err[5]); else passes++;
  endtask

  task automatic test_fifo();
    logic [63:0] wdata [4];
    int seen = 0;
    for (int i = 0; i < 4; i++) begin
      wdata[i] = {$urandom, $urandom};
      setCmd(C_WR, 2, 4 + i); tick();
      dfi_wrdata_en = 1'b1; dfi_wrdata = wdata[i]; dfi_wrdata_mask = 8'h00; tick();
    end
    for (int i = 0; i < 5; i++) begin
      setCmd(C_RD, 2, 4 + i); tick();
      checks++; if (err[5] !== (i == 4)) $display("FAIL fifo_rd_full_err5 rd%0d: got %b want %b", i, err[5], i == 4); else passes++;
    end
    for (int i = 0; i < 4; i++) begin
      dfi_rddata_en = 1'b1; tick();
    end
    for (int d = 0; d < 8; d++) begin
      checks++; if (dfi_rddata_valid !== mExpValid) $display("FAIL fifo_b2b_valid d%0d: got %b want %b", d, dfi_rddata_valid, mExpValid); else passes++;
      if (dfi_rddata_valid === 1'b1 && seen < 4) begin
        checks++; if (dfi_rddata !== wdata[seen]) $display("FAIL fifo_order w%0d: got %h want %h", seen, dfi_rddata, wdata[seen]); else passes++;
        seen++;
      end
      tick();
    end
    checks++; if (seen != 4) $display("FAIL fifo_valid_count: got %0d want 4", seen); else passes++;
    dfi_rddata_en = 1'b1; tick();
    for (int d = 0; d < TPHY_RDLAT + 2; d++) begin
      checks++; if (dfi_rddata_valid !== 1'b0) $display("FAIL fifo_empty_no_valid d%0d: got %b want 0", d, dfi_rddata_valid); else passes++;
      tick();
    end
    checks++; if (err !== mErr) $display("FAIL fifo_err_word: got %b want %b", err, mErr); else passes++;
  endtask

  task automatic test_reset_mid_read();
    int budget;
    setCmd(C_RD, 2, 3); tick();
    dfi_rddata_en = 1'b1; tick();
    tick();
    core_reset = 1'b1;
    modelReset();
    #1;
    checks++; if (err !== 6'd0) $display("FAIL midrst_err: got %b want 0", err); else passes++;
    checks++; if (dfi_rddata_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", dfi_rddata_valid); else passes++;
    checks++; if (dfi_rddata !== 64'd0) $display("FAIL midrst_rddata: got %h want 0", dfi_rddata); else passes++;
    checks++; if (dfi_init_complete !== 1'b0) $display("FAIL midrst_init: got %b want 0", dfi_init_complete); else passes++;
    tick(); tick(); tick();
    core_reset = 1'b0;
    for (int d = 0; d < 8; d++) begin
      tick();
      checks++; if (dfi_rddata_valid !== 1'b0) $display("FAIL midrst_dropped_valid d%0d: got %b want 0", d, dfi_rddata_valid); else passes++;
    end
    dfi_init_start = 1'b1;
    budget = 0;
    do begin
      tick();
      budget++;
    end while (dfi_init_complete !== 1'b1 && budget < 100);
    checks++; if (dfi_init_complete !== 1'b1) $display("FAIL midrst_reinit_timeout: got %b want 1", dfi_init_complete); else passes++;
    setCmd(C_ACT, 2, 1); tick();
    setCmd(C_RD, 2, 3);  tick();
    dfi_rddata_en = 1'b1; tick();
    for (int d = 1; d <= 6; d++) begin
      checks++; if (dfi_rddata_valid !== (d == TPHY_RDLAT)) $display("FAIL midrst_rb_valid d%0d: got %b want %b", d, dfi_rddata_valid, d == TPHY_RDLAT); else passes++;
      if (d == TPHY_RDLAT) begin
        checks++; if (dfi_rddata !== WORD_B) $display("FAIL midrst_rb_data: got %h want %h", dfi_rddata, WORD_B); else passes++;
      end
      tick();
    end
    checks++; if (err !== 6'd0) $display("FAIL midrst_err_after: got %b want 0", err); else passes++;
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: setCmd(C_ACT, $urandom_range(0, 3), $urandom_range(0, 3));
        2, 3: setCmd(C_RD, $urandom_range(0, 3), $urandom_range(0, 15));
        4, 5: setCmd(C_WR, $urandom_range(0, 3), $urandom_range(0, 15));
        6:    setCmd(C_PRE, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 1024 : 0);
        7:    setCmd(C_REF, 0, 0);
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        dfi_wrdata_en = 1'b1;
        dfi_wrdata = {$urandom, $urandom};
        dfi_wrdata_mask = 8'($urandom);
      end
      dfi_rddata_en = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (dfi_rddata_valid !== mExpValid) $display("FAIL rand_valid c%0d: got %b want %b", c, dfi_rddata_valid, mExpValid); else passes++;
      if (mExpValid && mExpKnown) begin
        checks++; if (dfi_rddata !== mExpData) $display("FAIL rand_data c%0d: got %h want %h", c, dfi_rddata, mExpData); else passes++;
      end
      checks++; if (err !== mErr) $display("FAIL rand_err c%0d: got %b want %b", c, err, mErr); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_byte_mask();
    test_bank_errors();
    test_fifo();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
